// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 4-digit scanned 7-segment driver.
//   disp_word_t : one display word (hex digits, decimal points, digit enables)
//   an_sel()    : active-low one-hot anode pattern for a digit index
package seg7_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_word_t;

  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    an_sel = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 and wraps.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for the last cycle of each slot (count == DIV-1)
module seg7_scan_prescaler #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int              CW   = $clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] presc_q;
  logic [CW-1:0] presc_d;

  always_comb begin
    tick    = (presc_q == LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes a 4-digit hex word onto one decoder nibble plus anodes.
// A pending word is captured on load and only copied into the active
// (displayed) word at a frame boundary, so a frame never mixes digits.
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : capture data/dp/en into the pending word
//   data, dp, en   : digit nibbles ([3:0] = digit 0), dots, enables
//   upd_ack        : 1-cycle pulse after a pending word is committed
//   hex, point, le : decoder nibble, dot, latch-enable (1 = digit shown)
//   an             : active-low digit anodes
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIV = 50_000,
  parameter int LZB = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  en,
  output logic        upd_ack,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic [3:0]  an
);

  logic tick;

  seg7_scan_prescaler #(.DIV(DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  disp_word_t pending_q, pending_d;
  disp_word_t active_q,  active_d;
  disp_word_t in_word;
  logic       pending_v_q, pending_v_d;
  logic [1:0] idx_q, idx_d;
  logic       upd_ack_q, upd_ack_d;
  logic [3:0] hex_q, hex_d;
  logic       point_q, point_d;
  logic       le_q, le_d;
  logic [3:0] an_q, an_d;
  logic       frame_end;
  logic [3:0] lz;
  logic       show;

  always_comb begin
    in_word     = '{data: data, dp: dp, en: en};
    frame_end   = tick && (idx_q == 2'd3);

    pending_d   = pending_q;
    pending_v_d = pending_v_q;
    active_d    = active_q;
    upd_ack_d   = 1'b0;
    idx_d       = idx_q;
    hex_d       = hex_q;
    point_d     = point_q;
    le_d        = le_q;
    an_d        = an_q;
    lz          = 4'b0000;
    show        = 1'b0;

    if (load) begin
      pending_d   = in_word;
      pending_v_d = 1'b1;
    end

    // A load landing on the frame boundary skips the pending stage.
    if (frame_end) begin
      if (load) begin
        active_d    = in_word;
        pending_v_d = 1'b0;
        upd_ack_d   = 1'b1;
      end else if (pending_v_q) begin
        active_d    = pending_q;
        pending_v_d = 1'b0;
        upd_ack_d   = 1'b1;
      end
    end

    // Leading zero: this digit and all more-significant digits are zero
    // with no dot requested. Digit 0 is never considered leading.
    lz[3] = (active_d.data[15:12] == 4'h0) && !active_d.dp[3];
    lz[2] = lz[3] && (active_d.data[11:8] == 4'h0) && !active_d.dp[2];
    lz[1] = lz[2] && (active_d.data[7:4]  == 4'h0) && !active_d.dp[1];
    lz[0] = 1'b0;

    if (tick) begin
      idx_d   = idx_q + 2'd1;
      show    = active_d.en[idx_d] && !((LZB != 0) && lz[idx_d]);
      hex_d   = active_d.data[{idx_d, 2'b00} +: 4];
      point_d = active_d.dp[idx_d];
      le_d    = show;
      an_d    = show ? an_sel(idx_d) : AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      pending_v_q <= 1'b0;
      active_q    <= '0;
      idx_q       <= 2'd0;
      upd_ack_q   <= 1'b0;
      hex_q       <= 4'h0;
      point_q     <= 1'b0;
      le_q        <= 1'b0;
      an_q        <= AN_OFF;
    end else begin
      pending_q   <= pending_d;
      pending_v_q <= pending_v_d;
      active_q    <= active_d;
      idx_q       <= idx_d;
      upd_ack_q   <= upd_ack_d;
      hex_q       <= hex_d;
      point_q     <= point_d;
      le_q        <= le_d;
      an_q        <= an_d;
    end
  end

  assign upd_ack = upd_ack_q;
  assign hex     = hex_q;
  assign point   = point_q;
  assign le      = le_q;
  assign an      = an_q;

endmodule
